// File: rtl/mvm_pkg.sv
// Shared constants and types for the MVM stream driver.
// No logic; consumed by the driver top level and its FIFOs.
// Not applicable.
package mvm_pkg;

    localparam int T_DEF        = 16;
    localparam int N_DEF        = 4;
    localparam int M_DEF        = 8;
    localparam int TX_VECS_DEF  = 4;
    localparam int RX_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RES
    } state_t;

    // Counter width that stays legal when the terminal count is 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty/count status.
// Latency: a pushed word is visible at head_data on the cycle after the push.
// Backpressure: push is dropped while full (even with a concurrent pop); pop is ignored while empty.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage array; contents need no reset since count guards every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mvm_stream_driver.sv
// Buffers host x-vectors, bursts them N words at a time into the MVM accelerator, collects M tagged results.
// Latency: SEND starts one edge after the N-th word lands in the TX FIFO; results reach res_* one cycle after capture.
// Backpressure: host stalls on TX full, bursts stall on acc_in_ready, result capture stalls on RX full.
module mvm_stream_driver import mvm_pkg::*; #(
    parameter int T        = T_DEF,
    parameter int N        = N_DEF,
    parameter int M        = M_DEF,
    parameter int TX_VECS  = TX_VECS_DEF,
    parameter int RX_DEPTH = RX_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         host_wr_valid,
    output logic         host_wr_ready,
    input  logic [T-1:0] host_wr_data,
    output logic         acc_in_valid,
    input  logic         acc_in_ready,
    output logic [T-1:0] acc_in_data,
    input  logic         acc_out_valid,
    output logic         acc_out_ready,
    input  logic [T-1:0] acc_out_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [T-1:0] res_data,
    output logic         res_last,
    output logic [15:0]  frames_done,
    output logic         busy
);

    localparam int TX_DEPTH = TX_VECS * N;
    localparam int TXCW     = $clog2(TX_DEPTH + 1);
    localparam int RXCW     = $clog2(RX_DEPTH + 1);
    localparam int SCW      = cnt_w(N);
    localparam int RCW      = cnt_w(M);

    state_t          state;
    state_t          state_nxt;
    logic [SCW-1:0]  send_cnt;
    logic [RCW-1:0]  res_cnt;

    logic            tx_full;
    logic            tx_empty;
    logic [TXCW-1:0] tx_count;
    logic [T-1:0]    tx_head;
    logic            tx_pop;

    logic            rx_full;
    logic            rx_empty;
    logic [RXCW-1:0] rx_count;
    logic [T:0]      rx_head;
    logic            rx_push;
    logic            rx_last_in;
    logic            send_last;
    logic            res_final;

    // FIFO status the control path never needs.
    logic            unused_status;
    assign unused_status = &{1'b0, tx_empty, rx_count};

    assign host_wr_ready = !tx_full && !reset;
    assign acc_in_data   = tx_head;
    assign send_last     = (send_cnt == SCW'(N - 1));
    assign rx_last_in    = (res_cnt == RCW'(M - 1));
    assign res_final     = rx_push && rx_last_in;
    assign res_valid     = !rx_empty;
    assign res_data      = rx_head[T-1:0];
    assign res_last      = !rx_empty && rx_head[T];
    assign busy          = (state != IDLE);

    sync_fifo #(.W(T), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (host_wr_valid && host_wr_ready),
        .push_data (host_wr_data),
        .pop       (tx_pop),
        .head_data (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    sync_fifo #(.W(T + 1), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data ({rx_last_in, acc_out_data}),
        .pop       (res_valid && res_ready),
        .head_data (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and stream handshake decode; one vector in flight at a time.
    always_comb begin
        state_nxt     = state;
        acc_in_valid  = 1'b0;
        acc_out_ready = 1'b0;
        tx_pop        = 1'b0;
        rx_push       = 1'b0;
        case (state)
            IDLE: begin
                if (tx_count >= TXCW'(N)) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                acc_in_valid = 1'b1;
                tx_pop       = acc_in_ready;
                if (acc_in_ready && send_last) begin
                    state_nxt = WAIT_RES;
                end
            end
            WAIT_RES: begin
                acc_out_ready = !rx_full;
                rx_push       = acc_out_valid && !rx_full;
                if (rx_push && rx_last_in) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word counters within a burst / result vector, and the completed-vector count.
    always_ff @(posedge clk) begin
        if (reset) begin
            send_cnt    <= '0;
            res_cnt     <= '0;
            frames_done <= '0;
        end else begin
            if (tx_pop) begin
                send_cnt <= send_last ? '0 : send_cnt + SCW'(1);
            end
            if (rx_push) begin
                res_cnt <= rx_last_in ? '0 : res_cnt + RCW'(1);
            end
            if (res_final) begin
                frames_done <= frames_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mvm_stream_driver.sv
// Directed + randomized bench for mvm_stream_driver with a queue-based host/accelerator model.
module tb_mvm_stream_driver;

    localparam int T = 16;
    localparam int N = 4;
    localparam int M = 8;

    logic         clk;
    logic         reset;
    logic         host_wr_valid;
    logic         host_wr_ready;
    logic [T-1:0] host_wr_data;
    logic         acc_in_valid;
    logic         acc_in_ready;
    logic [T-1:0] acc_in_data;
    logic         acc_out_valid;
    logic         acc_out_ready;
    logic [T-1:0] acc_out_data;
    logic         res_valid;
    logic         res_ready;
    logic [T-1:0] res_data;
    logic         res_last;
    logic [15:0]  frames_done;
    logic         busy;

    mvm_stream_driver #(.T(T), .N(N), .M(M), .TX_VECS(4), .RX_DEPTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_data  (host_wr_data),
        .acc_in_valid  (acc_in_valid),
        .acc_in_ready  (acc_in_ready),
        .acc_in_data   (acc_in_data),
        .acc_out_valid (acc_out_valid),
        .acc_out_ready (acc_out_ready),
        .acc_out_data  (acc_out_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_last      (res_last),
        .frames_done   (frames_done),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // Host side, expected accelerator input, accelerator result queue, expected result stream.
    logic [T-1:0] host_q[$];
    logic [T-1:0] exp_x[$];
    logic [T-1:0] res_pend[$];
    logic [T-1:0] fixed_res[$];
    logic [T:0]   exp_res[$];
    bit           pat[$];

    int in_rdy_mode;   // 0 fixed, 1 random, 2 pattern applied to cycles with valid high
    bit in_rdy_val, res_rdy_val, host_rand, out_rand, res_rand;
    int acc_cnt, out_cnt, frames_exp, edge_no, done_edge;
    bit done_valid;
    int host_acc_cnt, in_xfer_cnt, out_xfer_cnt, res_rcv, first_in_edge, last_in_edge;
    bit stall_prev;
    logic [T-1:0] stall_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive at negedge, sample handshakes just before the rising edge, update model after it.
    task automatic cycle();
        bit rst_s, h_x, i_x, o_x, r_x, r_l;
        logic [T-1:0] in_d, r_d, d;
        host_wr_valid = (host_q.size() > 0) && (!host_rand || ($urandom_range(0, 1) == 1));
        host_wr_data  = (host_q.size() > 0) ? host_q[0] : T'($urandom);
        case (in_rdy_mode)
            0:       acc_in_ready = in_rdy_val;
            1:       acc_in_ready = ($urandom_range(0, 1) == 1);
            default: acc_in_ready = !acc_in_valid ? 1'b0 : (pat.size() > 0) ? pat.pop_front() : 1'b1;
        endcase
        acc_out_valid = (res_pend.size() > 0) && (!out_rand || ($urandom_range(0, 1) == 1));
        acc_out_data  = (res_pend.size() > 0) ? res_pend[0] : T'($urandom);
        res_ready     = res_rand ? ($urandom_range(0, 1) == 1) : res_rdy_val;
        #4;
        rst_s = reset;
        h_x   = host_wr_valid && host_wr_ready;
        i_x   = acc_in_valid && acc_in_ready;
        o_x   = acc_out_valid && acc_out_ready;
        r_x   = res_valid && res_ready;
        in_d  = acc_in_data;
        r_d   = res_data;
        r_l   = res_last;
        if (stall_prev) begin
            chk("in_hold_valid", acc_in_valid, 1);
            chk("in_hold_data", acc_in_data, stall_data);
        end
        stall_prev = acc_in_valid && !acc_in_ready && !reset;
        stall_data = acc_in_data;
        @(posedge clk);
        edge_no++;
        @(negedge clk);
        if (rst_s) begin
            exp_x.delete();
            exp_res.delete();
            res_pend.delete();
            acc_cnt    = 0;
            out_cnt    = 0;
            frames_exp = 0;
            done_valid = 0;
        end else begin
            if (h_x) begin
                exp_x.push_back(host_q.pop_front());
                host_acc_cnt++;
            end
            if (i_x) begin
                chk("in_word_pending", exp_x.size() > 0, 1);
                if (exp_x.size() > 0) chk("acc_in_data", in_d, exp_x.pop_front());
                if (done_valid) begin
                    chk("send_gap_ge2", (edge_no - done_edge) >= 2, 1);
                    done_valid = 0;
                end
                if (in_xfer_cnt == 0) first_in_edge = edge_no;
                last_in_edge = edge_no;
                in_xfer_cnt++;
                acc_cnt++;
                if (acc_cnt == N) begin
                    acc_cnt = 0;
                    for (int m = 0; m < M; m++) begin
                        d = (fixed_res.size() > 0) ? fixed_res.pop_front() : T'($urandom);
                        res_pend.push_back(d);
                        exp_res.push_back({(m == M - 1), d});
                    end
                end
            end
            if (o_x) begin
                void'(res_pend.pop_front());
                out_xfer_cnt++;
                out_cnt++;
                if (out_cnt == M) begin
                    out_cnt    = 0;
                    frames_exp++;
                    done_edge  = edge_no;
                    done_valid = 1;
                end
            end
            if (r_x) begin
                chk("res_word_pending", exp_res.size() > 0, 1);
                if (exp_res.size() > 0) chk("res_last_data", {r_l, r_d}, exp_res.pop_front());
                res_rcv++;
            end
        end
    endtask

    // Run until every queued word has been sent and every result returned; expiry is a failure.
    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((host_q.size() > 0 || exp_x.size() > 0 || res_pend.size() > 0 ||
                exp_res.size() > 0 || busy) && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, n < budget, 1);
        chk({tag, "_frames"}, frames_done, frames_exp & 32'hFFFF);
    endtask

    initial begin
        int n, base, r0;
        bit any_v;
        reset = 1'b1;
        host_wr_valid = 0; host_wr_data = '0; acc_in_ready = 0;
        acc_out_valid = 0; acc_out_data = '0; res_ready = 0;
        in_rdy_mode = 0; in_rdy_val = 1; res_rdy_val = 1;
        host_rand = 0; out_rand = 0; res_rand = 0;
        acc_cnt = 0; out_cnt = 0; frames_exp = 0; edge_no = 0; done_edge = 0; done_valid = 0;
        host_acc_cnt = 0; in_xfer_cnt = 0; out_xfer_cnt = 0; res_rcv = 0;
        first_in_edge = 0; last_in_edge = 0; stall_prev = 0; stall_data = '0;
        @(negedge clk);

        // Reset state
        cycle(); cycle();
        chk("rst_host_wr_ready", host_wr_ready, 0);
        chk("rst_acc_in_valid", acc_in_valid, 0);
        chk("rst_acc_out_ready", acc_out_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frames_done", frames_done, 0);
        reset = 1'b0;
        cycle();
        chk("host_wr_ready_after_rst", host_wr_ready, 1);

        // Basic vector with known results
        for (int i = 10; i <= 17; i++) fixed_res.push_back(T'(i));
        for (int i = 1; i <= 4; i++) host_q.push_back(T'(i));
        in_xfer_cnt = 0; r0 = res_rcv;
        drain("basic_drain", 100);
        chk("basic_in_xfers", in_xfer_cnt, 4);
        chk("basic_in_consecutive", last_in_edge - first_in_edge, 3);
        chk("basic_res_count", res_rcv - r0, 8);
        chk("basic_frames_done", frames_done, 1);

        // Partial vector never starts
        for (int i = 0; i < 3; i++) host_q.push_back(T'($urandom));
        any_v = 0;
        repeat (50) begin
            cycle();
            if (acc_in_valid) any_v = 1;
        end
        chk("partial_no_valid", any_v, 0);
        base = host_acc_cnt; n = 0;
        host_q.push_back(T'($urandom));
        while (host_acc_cnt == base && n < 10) begin cycle(); n++; end
        chk("nth_word_accepted", host_acc_cnt - base, 1);
        cycle();
        chk("valid_after_nth", acc_in_valid, 1);
        drain("partial_drain", 100);

        // Input backpressure pattern
        in_rdy_mode = 2;
        pat = '{1, 0, 0, 1, 0, 1, 1};
        in_xfer_cnt = 0; n = 0;
        for (int i = 0; i < 4; i++) host_q.push_back(T'($urandom));
        while (!(busy && !acc_in_valid) && n < 40) begin cycle(); n++; end
        chk("bp_reached_wait", n < 40, 1);
        chk("bp_pattern_used", pat.size(), 0);
        chk("bp_in_xfers", in_xfer_cnt, 4);
        in_rdy_mode = 0; in_rdy_val = 1;
        drain("bp_drain", 100);

        // Output backpressure with the result FIFO full
        res_rdy_val = 0; out_xfer_cnt = 0; base = frames_exp;
        for (int i = 0; i < 8; i++) host_q.push_back(T'($urandom));
        repeat (60) cycle();
        chk("obp_accepted8", out_xfer_cnt, 8);
        chk("obp_out_ready_low", acc_out_ready, 0);
        chk("obp_busy", busy, 1);
        chk("obp_frames", frames_done, base + 1);
        chk("obp_res_valid", res_valid, 1);
        res_rdy_val = 1;
        cycle();
        res_rdy_val = 0;
        repeat (10) cycle();
        chk("obp_accepted9", out_xfer_cnt, 9);
        chk("obp_out_ready_low2", acc_out_ready, 0);
        res_rdy_val = 1;
        drain("obp_drain", 200);

        // TX FIFO full
        in_rdy_val = 0; host_acc_cnt = 0;
        for (int i = 0; i < 17; i++) host_q.push_back(T'($urandom));
        repeat (30) cycle();
        chk("txfull_accepted16", host_acc_cnt, 16);
        chk("txfull_ready_low", host_wr_ready, 0);
        in_rdy_val = 1;
        cycle();
        in_rdy_val = 0;
        cycle();
        chk("txfull_accepted17", host_acc_cnt, 17);
        for (int i = 0; i < 3; i++) host_q.push_back(T'($urandom));
        in_rdy_val = 1;
        drain("txfull_drain", 400);

        // Reset in the middle of SEND
        in_xfer_cnt = 0; n = 0;
        for (int i = 0; i < 8; i++) host_q.push_back(T'($urandom));
        while (in_xfer_cnt < 2 && n < 20) begin cycle(); n++; end
        chk("midsend_two_xfers", in_xfer_cnt, 2);
        reset = 1'b1;
        host_q.delete();
        cycle();
        chk("midrst_in_valid", acc_in_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_frames", frames_done, 0);
        chk("midrst_host_ready", host_wr_ready, 0);
        reset = 1'b0;
        cycle();
        chk("postrst_host_ready", host_wr_ready, 1);
        any_v = 0;
        repeat (6) begin
            cycle();
            if (acc_in_valid || res_valid) any_v = 1;
        end
        chk("postrst_fifos_empty", any_v, 0);
        for (int i = 0; i < 4; i++) host_q.push_back(T'($urandom));
        drain("postrst_drain", 100);
        chk("postrst_frames", frames_done, 1);

        // Randomized soak
        in_rdy_mode = 1; host_rand = 1; out_rand = 1; res_rand = 1;
        for (int i = 0; i < 40 * N; i++) host_q.push_back(T'($urandom));
        drain("soak_drain", 8000);
        chk("soak_frames", frames_done, 41);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
